// File: rtl/mem_sp_arbiter_pkg.sv
// Shared constants and FSM state encodings for the single-port memory arbiters.
package mem_sp_arbiter_pkg;
  localparam int IDATA_WIDTH  = 8;
  localparam int MAC_MULT_NUM = 4;
  localparam int RD_LAT_DEF   = 2;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_LOCK = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arb_rr_pick.sv
// Rotate-priority picker: first set request at or above i_start, wrapping to 0.
module mem_arb_rr_pick
  import mem_sp_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  int w_j;

  // Walk offsets downward so the smallest offset from i_start wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_j = int'(i_start) + off;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
        o_any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_sp_arbiter.sv
// Single-port SRAM arbiter with burst lock and tagged fixed-latency read return.
// MEM_ARB_FIXED_PRIO_EN: lowest-index-first instead of round-robin in ARB_IDLE.
module mem_sp_arbiter
  import mem_sp_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_BIT = IDATA_WIDTH * MAC_MULT_NUM,
  parameter int DEPTH    = 128,
  parameter int ADDR_BIT = $clog2(DEPTH),
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_wen,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_BIT-1:0]          rsp_rdata,
  output logic [ADDR_BIT-1:0]          mem_addr,
  output logic                         mem_wen,
  output logic                         mem_ren,
  output logic [DATA_BIT-1:0]          mem_wdata,
  input  logic [DATA_BIT-1:0]          mem_rdata
);
  localparam int IDX_W = idx_w(NUM_REQ);

  logic [0:0]                   r_state;
  logic [IDX_W-1:0]             r_lock_id;
  logic [IDX_W-1:0]             r_rr_ptr;
  logic [RD_LAT-1:0]            r_tag_vld;
  logic [RD_LAT-1:0][IDX_W-1:0] r_tag_id;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [IDX_W-1:0]   w_gidx;
  logic               w_issue;
  logic               w_gwen;
  logic [IDX_W-1:0]   w_ptr_nxt;

  mem_arb_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req   (req_valid),
    .i_start (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // While locked only the owner may issue, even if it is momentarily idle.
  always_comb begin
    w_gidx  = w_pick_idx;
    w_issue = w_pick_any;
    if (r_state == ARB_LOCK) begin
      w_gidx  = r_lock_id;
      w_issue = req_valid[r_lock_id];
    end
    if (rst) w_issue = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_gidx] = 1'b1;
  end

  assign w_gwen    = req_wen[w_gidx];
  assign mem_wen   = w_issue & w_gwen;
  assign mem_ren   = w_issue & ~w_gwen;
  assign mem_addr  = req_addr[int'(w_gidx)*ADDR_BIT +: ADDR_BIT];
  assign mem_wdata = req_wdata[int'(w_gidx)*DATA_BIT +: DATA_BIT];
  assign w_ptr_nxt = (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
    end else if (w_issue) begin
      if (r_state == ARB_IDLE) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        r_rr_ptr <= '0;
`else
        r_rr_ptr <= w_ptr_nxt;
`endif
      end
      if (req_lock[w_gidx]) begin
        r_state   <= ARB_LOCK;
        r_lock_id <= w_gidx;
      end else begin
        r_state   <= ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= mem_ren;
      r_tag_id[0]  <= mem_ren ? w_gidx : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (r_tag_vld[RD_LAT-1] && !rst) begin
      rsp_valid[r_tag_id[RD_LAT-1]] = 1'b1;
      rsp_rdata                     = mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_sp_arbiter.sv
// Directed bench for mem_sp_arbiter with a per-cycle reference model and SRAM model.
module tb_mem_sp_arbiter;
  import mem_sp_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int DB = IDATA_WIDTH * MAC_MULT_NUM;
  localparam int DP = 128;
  localparam int AB = $clog2(DP);
  localparam int RL = RD_LAT_DEF;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid, req_ready, req_wen, req_lock, rsp_valid;
  logic [NR*AB-1:0]   req_addr;
  logic [NR*DB-1:0]   req_wdata;
  logic [DB-1:0]      rsp_rdata, mem_wdata, mem_rdata;
  logic [AB-1:0]      mem_addr;
  logic               mem_wen, mem_ren;

  int errors = 0;
  int checks = 0;

  mem_sp_arbiter #(.NUM_REQ(NR), .DATA_BIT(DB), .DEPTH(DP), .ADDR_BIT(AB), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM instance model: read data valid RL cycles after mem_ren
  logic [DB-1:0] sram [DP];
  logic [DB-1:0] rpipe [RL];
  initial for (int i = 0; i < DP; i++) sram[i] = '0;
  initial for (int i = 0; i < RL; i++) rpipe[i] = '0;
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    rpipe[0] <= mem_ren ? sram[mem_addr] : '0;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RL-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: arbitration rules, lock, memory contents, pending responses
  typedef struct { int due; int id; logic [DB-1:0] data; } rsp_t;
  rsp_t          rspq[$];
  logic [DB-1:0] m_mem [DP];
  int            m_ptr, m_lock_id, cyc;
  bit            m_lock;

  initial begin
    int            eg, a;
    logic [63:0]   e_rdy, e_rv, e_rd;
    rsp_t          r;
    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    m_ptr = 0; m_lock = 0; m_lock_id = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_memen", {mem_wen, mem_ren}, 0);
        m_ptr = 0; m_lock = 0;
        rspq.delete();
      end else begin
        eg = -1;
        if (m_lock) begin
          if (req_valid[m_lock_id]) eg = m_lock_id;
        end else begin
          for (int k = NR - 1; k >= 0; k--)
            if (req_valid[(m_ptr + k) % NR]) eg = (m_ptr + k) % NR;
        end
        e_rdy = (eg >= 0) ? (64'd1 << eg) : 64'd0;
        chk("ready", req_ready, e_rdy);
        chk("mem_wen", mem_wen, (eg >= 0) && req_wen[eg]);
        chk("mem_ren", mem_ren, (eg >= 0) && !req_wen[eg]);
        if (eg >= 0) begin
          a = int'(req_addr[eg*AB +: AB]);
          chk("mem_addr", mem_addr, a);
          if (req_wen[eg]) chk("mem_wdata", mem_wdata, req_wdata[eg*DB +: DB]);
        end
        e_rv = 0; e_rd = 0;
        if (rspq.size() > 0 && rspq[0].due == cyc) begin
          r = rspq.pop_front();
          e_rv = 64'd1 << r.id;
          e_rd = r.data;
        end
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_rdata", rsp_rdata, e_rd);
        if (eg >= 0) begin
          if (req_wen[eg]) m_mem[a] = req_wdata[eg*DB +: DB];
          else begin
            r.due = cyc + RL; r.id = eg; r.data = m_mem[a];
            rspq.push_back(r);
          end
`ifndef MEM_ARB_FIXED_PRIO_EN
          if (!m_lock) m_ptr = (eg + 1) % NR;
`endif
          m_lock    = req_lock[eg];
          m_lock_id = eg;
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_wen = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic drv(input int i, input bit v, input bit w, input bit l, input int a,
                     input logic [DB-1:0] d);
    req_valid[i] = v; req_wen[i] = w; req_lock[i] = l;
    req_addr[i*AB +: AB] = AB'(a);
    req_wdata[i*DB +: DB] = d;
  endtask

  initial begin
    logic [63:0] e;
    rst = 1'b1;
    idle();
    step();
    @(negedge clk);
    chk("t0_reset_outputs", {rsp_rdata, req_ready, rsp_valid, mem_wen, mem_ren}, 0);
    step();
    rst = 1'b0;

    // 1: write then read-back by req0
    drv(0, 1, 1, 0, 5, 'hAA);
    @(negedge clk);
    chk("t1_wr_ready", req_ready, 4'b0001);
    chk("t1_wen", {mem_wen, mem_ren}, 2'b10);
    step();
    drv(0, 1, 0, 0, 5, 0);
    @(negedge clk);
    chk("t1_rd", {mem_wen, mem_ren, mem_addr}, {2'b01, AB'(5)});
    step();
    idle();
    for (int i = 1; i < RL; i++) begin
      @(negedge clk);
      chk("t1_early_rsp", rsp_valid, 0);
      step();
    end
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_rdata", rsp_rdata, 'hAA);
    step();

    // 2: all four reading continuously from rr_ptr = 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) drv(i, 1, 0, 0, 10 + i, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("t2_grant", req_ready, 4'b0001);
      if (k >= RL) chk("t2_rsp_id", rsp_valid, 4'b0001);
`else
      e = 64'd1 << (k % NR);
      chk("t2_grant", req_ready, e);
      e = 64'd1 << ((k - RL) % NR);
      if (k >= RL) chk("t2_rsp_id", rsp_valid, e);
`endif
      step();
    end
    idle();
    repeat (RL + 1) step();

    // 3: req2 locked burst (1,1,0) with an idle hole; req1 waits 3 cycles
    drv(2, 1, 1, 1, 20, 'h2000);
    @(negedge clk); chk("t3_c0", req_ready, 4'b0100); step();
    drv(2, 0, 0, 0, 0, 0);
    drv(1, 1, 1, 0, 30, 'h1000);
    @(negedge clk); chk("t3_c1_idle_lock", req_ready, 4'b0000); step();
    drv(2, 1, 1, 1, 21, 'h2001);
    @(negedge clk); chk("t3_c2", req_ready, 4'b0100); step();
    drv(2, 1, 1, 0, 22, 'h2002);
    @(negedge clk); chk("t3_c3_last", req_ready, 4'b0100); step();
    drv(2, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t3_c4_req1", req_ready, 4'b0010); step();
    idle();
    step();

    // 4: reset one cycle after a read; response must be dropped
    drv(0, 1, 0, 0, 5, 0);
    @(negedge clk); chk("t4_rd", mem_ren, 1); step();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_outputs", {req_ready, rsp_valid, mem_wen, mem_ren}, 0);
    step();
    rst = 1'b0;
    idle();
    for (int i = 0; i < RL + 1; i++) begin
      @(negedge clk);
      chk("t4_no_rsp", rsp_valid, 0);
      step();
    end

    // 5: req1 and req3 always valid
    drv(1, 1, 0, 0, 40, 0);
    drv(3, 1, 0, 0, 41, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("t5_grant", req_ready, 4'b0010);
`else
      chk("t5_grant", req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
`endif
      step();
    end
    idle();
    repeat (RL + 1) step();

    // 6: write by req0 then same-address read by req1
    drv(0, 1, 1, 0, 7, 'h12345678);
    @(negedge clk); chk("t6_wr", req_ready, 4'b0001); step();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 7, 0);
    @(negedge clk); chk("t6_rd", req_ready, 4'b0010); step();
    idle();
    repeat (RL - 1) step();
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 4'b0010);
    chk("t6_rsp_rdata", rsp_rdata, 'h12345678);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
